// File: rtl/row_maxpool.sv
`default_nettype none
// ============================================================================
//  Module      : row_maxpool
//  Description : Pairs consecutive convolution output rows, performs 2x2
//                signed max-pooling with optional ReLU and streams the pooled
//                words serially over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module row_maxpool #(
    parameter int WORDWIDTH = 32,
    parameter int ROWLEN    = 10,
    parameter int RELU_EN   = 1,
    localparam int COL_W    = (ROWLEN / 2 > 1) ? $clog2(ROWLEN / 2) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ROWLEN*WORDWIDTH-1:0] row_in,
    input  logic                        row_valid,
    input  logic                        row_last,
    output logic                        row_ready,
    output logic [WORDWIDTH-1:0]        pool_data,
    output logic                        pool_valid,
    input  logic                        pool_ready,
    output logic [COL_W-1:0]            pool_col,
    output logic                        pool_row_last,
    output logic                        pool_frame_last
);

    localparam int               c_half     = ROWLEN / 2;
    localparam logic [COL_W-1:0] c_col_last = COL_W'(c_half - 1);

    typedef enum logic [1:0] {
        ST_EVEN = 2'd0,
        ST_ODD  = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [ROWLEN*WORDWIDTH-1:0] r_buf_a;
    logic [ROWLEN*WORDWIDTH-1:0] r_buf_b;
    logic [COL_W-1:0]            r_col;
    logic                        r_frame;
    logic                        w_row_acc;
    logic                        w_xfer;
    logic                        w_col_at_last;
    logic [WORDWIDTH-1:0]        w_pool [c_half];

    assign w_col_at_last = (r_col == c_col_last);

    // Per-column 2x2 signed maximum with optional clamp of negatives to zero
    for (genvar c = 0; c < c_half; c++) begin : g_col
        logic signed [WORDWIDTH-1:0] w_a0, w_a1, w_b0, w_b1;
        logic signed [WORDWIDTH-1:0] w_mx_a, w_mx_b, w_mx;
        assign w_a0   = $signed(r_buf_a[(2*c)*WORDWIDTH   +: WORDWIDTH]);
        assign w_a1   = $signed(r_buf_a[(2*c+1)*WORDWIDTH +: WORDWIDTH]);
        assign w_b0   = $signed(r_buf_b[(2*c)*WORDWIDTH   +: WORDWIDTH]);
        assign w_b1   = $signed(r_buf_b[(2*c+1)*WORDWIDTH +: WORDWIDTH]);
        assign w_mx_a = (w_a0 > w_a1) ? w_a0 : w_a1;
        assign w_mx_b = (w_b0 > w_b1) ? w_b0 : w_b1;
        assign w_mx   = (w_mx_a > w_mx_b) ? w_mx_a : w_mx_b;
        assign w_pool[c] = ((RELU_EN != 0) && w_mx[WORDWIDTH-1]) ? '0 : w_mx;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EVEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake outputs; reset holds off new rows
    always_comb begin
        w_state_next = r_state;
        row_ready    = 1'b0;
        pool_valid   = 1'b0;
        w_row_acc    = 1'b0;
        w_xfer       = 1'b0;
        case (r_state)
            ST_EVEN: begin
                row_ready = !rst;
                w_row_acc = row_valid && row_ready;
                if (w_row_acc && !row_last) begin
                    w_state_next = ST_ODD;
                end
            end
            ST_ODD: begin
                row_ready = !rst;
                w_row_acc = row_valid && row_ready;
                if (w_row_acc) begin
                    w_state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                pool_valid = 1'b1;
                w_xfer     = pool_ready;
                if (w_xfer && w_col_at_last) begin
                    w_state_next = ST_EVEN;
                end
            end
            default: begin
                w_state_next = ST_EVEN;
            end
        endcase
    end

    // Row buffers, output column counter and end-of-frame flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_a <= '0;
            r_buf_b <= '0;
            r_col   <= '0;
            r_frame <= 1'b0;
        end else begin
            case (r_state)
                ST_EVEN: begin
                    // A lone final row has no partner and is dropped
                    if (w_row_acc && !row_last) begin
                        r_buf_a <= row_in;
                    end
                end
                ST_ODD: begin
                    if (w_row_acc) begin
                        r_buf_b <= row_in;
                        r_frame <= row_last;
                        r_col   <= '0;
                    end
                end
                ST_EMIT: begin
                    if (w_xfer) begin
                        if (w_col_at_last) begin
                            r_col   <= '0;
                            r_frame <= 1'b0;
                        end else begin
                            r_col   <= r_col + COL_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pool_data       = w_pool[r_col];
    assign pool_col        = r_col;
    assign pool_row_last   = pool_valid && w_col_at_last;
    assign pool_frame_last = pool_row_last && r_frame;

endmodule
`default_nettype wire

// File: tb/tb_row_maxpool.sv
`default_nettype none
// ============================================================================
//  Module      : tb_row_maxpool
//  Description : Self-checking bench for row_maxpool; one instance with ReLU
//                and one without share the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_row_maxpool;

    localparam int W  = 32;
    localparam int L  = 10;
    localparam int H  = L / 2;
    localparam int CW = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         row_valid = 1'b0;
    logic         row_last = 1'b0;
    logic         pool_ready = 1'b0;
    logic [L*W-1:0] row_in = '0;

    logic          rr_r, pv_r, prl_r, pfl_r;
    logic [W-1:0]  pd_r;
    logic [CW-1:0] pc_r;
    logic          rr_n, pv_n, prl_n, pfl_n;
    logic [W-1:0]  pd_n;
    logic [CW-1:0] pc_n;

    row_maxpool #(.WORDWIDTH(W), .ROWLEN(L), .RELU_EN(1)) u_relu (
        .clk(clk), .rst(rst), .row_in(row_in), .row_valid(row_valid),
        .row_last(row_last), .row_ready(rr_r), .pool_data(pd_r),
        .pool_valid(pv_r), .pool_ready(pool_ready), .pool_col(pc_r),
        .pool_row_last(prl_r), .pool_frame_last(pfl_r)
    );

    row_maxpool #(.WORDWIDTH(W), .ROWLEN(L), .RELU_EN(0)) u_raw (
        .clk(clk), .rst(rst), .row_in(row_in), .row_valid(row_valid),
        .row_last(row_last), .row_ready(rr_n), .pool_data(pd_n),
        .pool_valid(pv_n), .pool_ready(pool_ready), .pool_col(pc_n),
        .pool_row_last(prl_n), .pool_frame_last(pfl_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        int relu;
        int raw;
        int col;
        bit rl;
        bit fl;
    } exp_t;

    exp_t exp_q[$];
    int   m_a[L];
    bit   m_have = 1'b0;
    bit   m_acc  = 1'b0;
    int   obs_relu[$];
    int   obs_raw[$];
    bit   obs_rl[$];
    bit   obs_fl[$];
    int   n_total = 0;
    int   n_bad   = 0;

    int ra[L] = '{1, 5, 2, 2, -3, -1, 7, 0, 4, 4};
    int rb[L] = '{3, 0, 2, 9, -8, -2, 6, 8, 4, 4};
    int er[H] = '{5, 9, 0, 8, 4};
    int en[H] = '{5, 9, -1, 8, 4};

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [L*W-1:0] pack_row(input int w[L]);
        logic [L*W-1:0] r;
        for (int k = 0; k < L; k++) r[k*W +: W] = w[k];
        return r;
    endfunction

    function automatic int rnd_word();
        case ($urandom_range(0, 5))
            0:       return int'($urandom);
            1:       return int'(32'h8000_0000);
            2:       return int'(32'h7fff_ffff);
            default: return int'($urandom_range(0, 40)) - 20;
        endcase
    endfunction

    function automatic logic [L*W-1:0] rnd_row();
        int w[L];
        for (int k = 0; k < L; k++) w[k] = rnd_word();
        return pack_row(w);
    endfunction

    // Compare every DUT output against the model queue head
    task automatic observe();
        bit busy;
        busy = (exp_q.size() != 0);
        check_val("row_ready",   rr_r, (!rst && !busy));
        check_val("row_ready_n", rr_n, (!rst && !busy));
        check_val("pool_valid",  pv_r, busy);
        check_val("pool_valid_n", pv_n, busy);
        if (busy) begin
            check_val("data_relu", longint'($signed(pd_r)), exp_q[0].relu);
            check_val("data_raw",  longint'($signed(pd_n)), exp_q[0].raw);
            check_val("col",       pc_r,  exp_q[0].col);
            check_val("col_n",     pc_n,  exp_q[0].col);
            check_val("row_last",  prl_r, exp_q[0].rl);
            check_val("frame_last", pfl_r, exp_q[0].fl);
            check_val("frame_last_n", pfl_n, exp_q[0].fl);
        end
        if (pv_r && pool_ready) begin
            obs_relu.push_back(int'($signed(pd_r)));
            obs_raw.push_back(int'($signed(pd_n)));
            obs_rl.push_back(prl_r);
            obs_fl.push_back(pfl_r);
        end
    endtask

    // What the coming edge does: rows pair up, each pair yields H outputs
    task automatic model_edge();
        int w[L];
        m_acc = 1'b0;
        if (rst) begin
            exp_q.delete();
            m_have = 1'b0;
        end else if (exp_q.size() != 0) begin
            if (pool_ready) void'(exp_q.pop_front());
        end else if (row_valid) begin
            m_acc = 1'b1;
            for (int k = 0; k < L; k++) w[k] = int'($signed(row_in[k*W +: W]));
            if (!m_have) begin
                if (!row_last) begin
                    m_a    = w;
                    m_have = 1'b1;
                end
            end else begin
                for (int c = 0; c < H; c++) begin
                    exp_t e;
                    int   m;
                    m = m_a[2*c];
                    if (m_a[2*c+1] > m) m = m_a[2*c+1];
                    if (w[2*c] > m)     m = w[2*c];
                    if (w[2*c+1] > m)   m = w[2*c+1];
                    e.raw  = m;
                    e.relu = (m < 0) ? 0 : m;
                    e.col  = c;
                    e.rl   = (c == H - 1);
                    e.fl   = (c == H - 1) && row_last;
                    exp_q.push_back(e);
                end
                m_have = 1'b0;
            end
        end
    endtask

    task automatic step(input bit n_rst, input bit n_rv, input bit n_rl,
                        input bit n_pr, input logic [L*W-1:0] n_row);
        @(negedge clk);
        observe();
        rst        = n_rst;
        row_valid  = n_rv;
        row_last   = n_rl;
        pool_ready = n_pr;
        row_in     = n_row;
        model_edge();
    endtask

    task automatic send_row(input logic [L*W-1:0] r, input bit last);
        int k;
        k = 0;
        m_acc = 1'b0;
        while (!m_acc && k < 100) begin
            step(1'b0, 1'b1, last, 1'b1, r);
            k++;
        end
        if (!m_acc) check_val("send_timeout", 0, 1);
    endtask

    task automatic drain(input int stall, input bit rv, input logic [L*W-1:0] r);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            for (int s = 0; s < stall; s++) step(1'b0, rv, 1'b0, 1'b0, r);
            step(1'b0, rv, 1'b0, 1'b1, r);
            k++;
        end
        if (exp_q.size() != 0) check_val("drain_timeout", 0, 1);
    endtask

    task automatic clear_obs();
        obs_relu.delete();
        obs_raw.delete();
        obs_rl.delete();
        obs_fl.delete();
    endtask

    task automatic check_basic(input string tag);
        check_val({tag, "_count"}, obs_relu.size(), H);
        if (obs_relu.size() == H) begin
            for (int i = 0; i < H; i++) begin
                check_val({tag, "_relu"}, obs_relu[i], er[i]);
                check_val({tag, "_raw"},  obs_raw[i],  en[i]);
                check_val({tag, "_rl"},   obs_rl[i],   (i == H - 1));
                check_val({tag, "_fl"},   obs_fl[i],   0);
            end
        end
    endtask

    initial begin
        logic [L*W-1:0] rr;
        int nfl;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        check_val("rst_col", pc_r, 0);
        check_val("rst_rl",  prl_r, 0);
        check_val("rst_fl",  pfl_r, 0);

        // Basic pooling, both ReLU settings
        clear_obs();
        send_row(pack_row(ra), 1'b0);
        send_row(pack_row(rb), 1'b0);
        drain(0, 1'b0, '0);
        check_basic("basic");

        // Backpressure with a competing row held during EMIT
        clear_obs();
        send_row(pack_row(ra), 1'b0);
        send_row(pack_row(rb), 1'b0);
        rr = rnd_row();
        drain(3, 1'b1, rr);
        check_basic("stall");
        send_row(rr, 1'b0);
        send_row(rnd_row(), 1'b0);
        drain(0, 1'b0, '0);

        // Odd frame: trailing row discarded
        clear_obs();
        send_row(rnd_row(), 1'b0);
        send_row(rnd_row(), 1'b0);
        send_row(rnd_row(), 1'b1);
        drain(0, 1'b0, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        check_val("odd_count", obs_relu.size(), H);
        nfl = 0;
        foreach (obs_fl[i]) nfl += obs_fl[i];
        check_val("odd_fl_count", nfl, 0);

        // Even frame end
        clear_obs();
        send_row(rnd_row(), 1'b0);
        send_row(rnd_row(), 1'b0);
        send_row(rnd_row(), 1'b0);
        send_row(rnd_row(), 1'b1);
        drain(0, 1'b0, '0);
        check_val("even_count", obs_fl.size(), 2 * H);
        nfl = 0;
        foreach (obs_fl[i]) nfl += obs_fl[i];
        check_val("even_fl_count", nfl, 1);
        if (obs_fl.size() == 2 * H) check_val("even_fl_pos", obs_fl[2*H-1], 1);

        // Reset after the col-1 transfer
        send_row(pack_row(ra), 1'b0);
        send_row(pack_row(rb), 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        step(1'b1, 1'b1, 1'b0, 1'b1, pack_row(ra));
        step(1'b1, 1'b1, 1'b0, 1'b1, pack_row(ra));
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        check_val("rst2_col", pc_r, 0);
        check_val("rst2_pv",  pv_r, 0);
        check_val("rst2_rr",  rr_r, 0);
        clear_obs();
        send_row(pack_row(rb), 1'b0);
        send_row(pack_row(ra), 1'b0);
        drain(0, 1'b0, '0);
        check_basic("after_rst");

        // Randomized traffic
        rr = rnd_row();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) < 7),
                 rr);
            if (m_acc) rr = rnd_row();
        end
        drain(0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/row_maxpool.md
Name: row_maxpool

Overview:
- Downstream stage of the convolution row-sum unit.
- Consumes complete output rows of a convolution layer (ROWLEN words, presented in parallel) and pairs consecutive rows.
- Performs 2x2 max-pooling with optional ReLU and streams the pooled words serially over a valid/ready handshake to the next layer's buffer.
- Tracks row pairing across a feature map; an odd trailing row is discarded (floor pooling).

Parameters:
- WORDWIDTH, 32, width of one signed two's-complement word.
- ROWLEN, 10, words per input row; must be even and >= 2.
- RELU_EN, 1, 1 = clamp negative pooled results to 0; 0 = pass signed maximum unchanged.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- row_in  input  ROWLEN*WORDWIDTH  input row; word k at bits [k*WORDWIDTH +: WORDWIDTH], word 0 = leftmost column.
- row_valid  input  1  row_in/row_last valid.
- row_last  input  1  row is the final row of the feature map.
- row_ready  output  1  block can accept a row this cycle.
- pool_data  output  WORDWIDTH  pooled word.
- pool_valid  output  1  pool_data valid.
- pool_ready  input  1  downstream accepts pool_data.
- pool_col  output  $clog2(ROWLEN/2) (min 1)  output column index of pool_data.
- pool_row_last  output  1  pool_data is the last word of the pooled row.
- pool_frame_last  output  1  pool_data is the last word of the pooled feature map.

Behaviour:
- Row accept occurs when row_valid && row_ready at a rising edge of clk. Output transfer occurs when pool_valid && pool_ready at a rising edge.
- FSM states:
  - EVEN: waiting for the first row of a pair. row_ready = 1.
    - Accept with row_last = 0 → latch row_in into buf_a, go to ODD.
    - Accept with row_last = 1 → discard the row, stay in EVEN. No output is produced.
  - ODD: buf_a is held. row_ready = 1.
    - Accept → latch row_in into buf_b, latch row_last into frame_flag, clear col, go to EMIT.
  - EMIT: row_ready = 0. pool_valid = 1.
    - Each transfer increments col.
    - The transfer with col == ROWLEN/2-1 returns the FSM to EVEN and clears frame_flag.
- pool_data for column c:
  - m = signed max(buf_a[2c], buf_a[2c+1], buf_b[2c], buf_b[2c+1]).
  - If RELU_EN = 1 and m < 0, the output is 0. Otherwise the output is m.
  - Comparisons are full-width signed; there is no truncation or saturation.
- pool_data, pool_col, pool_row_last and pool_frame_last are driven from registered state only. They hold stable while pool_valid && !pool_ready; there is no combinational path from pool_ready or row_valid to any output.
- pool_col = col. pool_row_last = EMIT && col == ROWLEN/2-1. pool_frame_last = pool_row_last && frame_flag.
- Latency: the second row is accepted at edge N; pool_valid is high in the cycle after edge N; column c is transferred no earlier than edge N+1+c.
- Throughput: one pair of rows per (2 + ROWLEN/2) cycles when downstream never stalls.
- row_ready deasserts the cycle after the second-row accept and reasserts the cycle after the final column transfer.
- Backpressure: pool_ready may be held low indefinitely. State, col and buffers hold; pool_valid stays 1.
- rst (synchronous, any state including mid-EMIT):
  - Next state is EVEN, col = 0, frame_flag = 0, buf_a = buf_b = 0.
  - pool_valid = 0, pool_row_last = 0, pool_frame_last = 0, pool_col = 0.
  - row_ready is forced to 0 while rst is high.
  - A partially emitted row is dropped.
- row_valid while row_ready = 0 is ignored; the upstream must hold the row.
- pool_valid is never asserted outside EMIT.

Test Plan:
- Basic pooling, RELU_EN=1:
  - Stimulus: row A words 0..9 = 1,5,2,2,-3,-1,7,0,4,4; row B = 3,0,2,9,-8,-2,6,8,4,4; row_last = 0 on both; pool_ready = 1.
  - Required: pool_data 5,9,0,8,4 at pool_col 0..4 on consecutive cycles; pool_row_last on col 4 only; pool_frame_last = 0.
- ReLU disabled:
  - Stimulus: same as the first scenario with RELU_EN=0.
  - Required: col 2 outputs -1 (0xFFFFFFFF); all other outputs unchanged.
- Backpressure:
  - Stimulus: pool_ready low for 3 cycles after each transfer.
  - Required: same 5 values; each value held stable while stalled; row_ready = 0 throughout EMIT; a new row_valid during EMIT is not accepted.
- Odd frame:
  - Stimulus: 3 rows, third with row_last = 1.
  - Required: exactly 5 outputs; third row discarded; FSM returns to EVEN; pool_frame_last never asserted.
- Even frame end:
  - Stimulus: rows 1..4 with row_last on row 4.
  - Required: 10 outputs; pool_frame_last = 1 only on the 10th output (col 4).
- Reset mid-EMIT:
  - Stimulus: assert rst after the col-1 transfer.
  - Required: next cycle pool_valid = 0 and row_ready = 0 while rst is held. After release, row_ready = 1 and the next two rows pool from zeroed buffers with no stale values.
